period_timer: RTL and testbench
===============================

Name: period_timer

Overview:
Parametrised successor to the game's post-period timer. Runs a countdown of a runtime-selectable number of seconds, with an internal prescaler on the system clock. Drives a live per-digit seven-segment countdown and emits a one-cycle completion pulse to the level sequencer. Supports abort, optional pause, and a parameter-default duration when the requested duration is zero.

Parameters:
TICK_DIV, 100000000, Clk100M cycles per second tick (>=2)
DUR_W, 8, width of duration/remaining count
PERIOD_SEC, 5, default duration used when durSec==0 (1..2^DUR_W-1)
NUM_DIGITS, 4, seven-seg digits driven; must hold max BCD of DUR_W bits (4*NUM_DIGITS >= DUR_W+ceil(DUR_W/3))

Ports:
Clk100M  in  1  system clock, all logic on rising edge
RstN  in  1  asynchronous active-low reset
startSig  in  1  start request, level-sampled each cycle
abortSig  in  1  abort request, highest priority
pauseSig  in  1  hold countdown while high (see Optional Feature)
durSec  in  DUR_W  duration in seconds, sampled on accepted start; 0 selects PERIOD_SEC
running  out  1  high in LOAD, RUN, PAUSE
remaining  out  DUR_W  seconds remaining, binary
periodComplete  out  1  one-cycle pulse at natural expiry
segOut  out  8*NUM_DIGITS  digit i at [8i+7:8i]; active-low {dp,g,f,e,d,c,b,a}; digit 0 = units

Behaviour:
- All outputs registered. Reset (RstN low, async): state IDLE, remaining 0, periodComplete 0, running 0, prescaler 0, segOut all 8'hFF (blank).
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- IDLE: startSig high and abortSig low -> latch dur = (durSec==0 ? PERIOD_SEC : durSec) into remaining and a shift register; go LOAD. This sampling edge is edge 0.
- LOAD: shift-add-3 binary-to-BCD over exactly DUR_W cycles. At edge DUR_W go RUN, prescaler = 0, BCD count valid. segOut stays blank during LOAD.
- RUN: prescaler increments each cycle. At prescaler==TICK_DIV-1 it wraps to 0, which is a tick. Each tick decrements remaining and the BCD count, with digit borrow 0->9 propagating upward.
  - Tick with remaining==1: remaining 0, go DONE, periodComplete high.
  - Completion edge = DUR_W + dur*TICK_DIV, counted from edge 0 with no pause.
- DONE: periodComplete high for exactly this one cycle. segOut shows all digits "0". Next edge -> IDLE.
- IDLE after DONE: segOut holds the zeros until the next start. remaining stays 0.
- segOut in RUN/PAUSE: every digit decoded from BCD, leading zeros shown, dp off.
- startSig while not IDLE is ignored; no restart.
- abortSig high in any state: next edge -> IDLE. periodComplete stays 0, remaining 0, segOut blank, prescaler 0. Abort wins over start and over a coincident final tick.
- startSig held high across DONE->IDLE: a new run begins on the first IDLE edge.
- Reset mid-run: immediate return to reset values, no pulse.
- PAUSE (feature enabled): entered from RUN when pauseSig is high. Prescaler, remaining and segOut are frozen. Returns to RUN at the first edge with pauseSig low, and the prescaler resumes from its held value. Pause during LOAD takes effect only on entry to RUN.

Optional Feature:
PERIOD_PAUSE_EN
- Defined: PAUSE state present, pauseSig honoured as above.
- Undefined: pauseSig ignored, PAUSE state not synthesised, RUN never holds.

Test Plan:
(TICK_DIV=4, DUR_W=8, NUM_DIGITS=4, PERIOD_SEC=5 unless noted)
- Start durSec=3 -> running at edge 1; remaining 3, segOut digits 0,0,0,3 at edge 8; remaining 2 at edge 12, 1 at 16; periodComplete high for one cycle after edge 20; then IDLE with segOut "0000".
- Start durSec=0 -> remaining loads 5; periodComplete after edge 8+20=28.
- durSec=255 -> segOut "0255" after LOAD; ticks show "0254", then 100->"0099" borrow across two digits.
- Start durSec=3, abort at edge 15 -> IDLE at edge 16; periodComplete never asserts; segOut 8'hFF per digit; remaining 0.
- Start and abort in the same cycle -> stays IDLE; next cycle start alone -> normal run.
- PERIOD_PAUSE_EN defined: durSec=2, pauseSig high edges 10..19 -> remaining frozen; completion delayed by 10 cycles to edge 26. Undefined: same stimulus completes at edge 16.

Source files
------------

// File: rtl/period_timer.sv
// period_timer: seconds countdown with prescaler and BCD seven-seg readout.
// Define PERIOD_PAUSE_EN to build the PAUSE state honouring pauseSig.
module period_timer #(
  parameter int TICK_DIV   = 100000000,
  parameter int DUR_W      = 8,
  parameter int PERIOD_SEC = 5,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    Clk100M,
  input  logic                    RstN,
  input  logic                    startSig,
  input  logic                    abortSig,
  input  logic                    pauseSig,
  input  logic [DUR_W-1:0]        durSec,
  output logic                    running,
  output logic [DUR_W-1:0]        remaining,
  output logic                    periodComplete,
  output logic [8*NUM_DIGITS-1:0] segOut
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int SW = 8 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DUR_W + 1);

  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST   = CW'(DUR_W - 1);

`ifdef PERIOD_PAUSE_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_PAUSE, S_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DONE
  } state_e;
  logic unused_pause;
  assign unused_pause = pauseSig;
`endif

  state_e          state_q, state_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [DUR_W-1:0] sh_q, sh_d;
  logic [PW-1:0]   ps_q, ps_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [SW-1:0]   seg_q, seg_d;
  logic            run_q, run_d;
  logic            done_q, done_d;
  logic            adv;
  logic [DUR_W-1:0] dur;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    unique case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [SW-1:0] seg_of(
    input logic [BW-1:0] b
  );
    logic [SW-1:0] s;
    s = '1;
    for (int i = 0; i < NUM_DIGITS; i++)
      s[8*i +: 8] = seg7(b[4*i +: 4]);
    return s;
  endfunction

  function automatic logic [BW-1:0] bcd_shift(
    input logic [BW-1:0] b,
    input logic          bit_in
  );
    logic [BW-1:0] t;
    t = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (t[4*i +: 4] >= 4'd5)
        t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    return {t[BW-2:0], bit_in};
  endfunction

  // Borrow ripples upward through zero digits
  function automatic logic [BW-1:0] bcd_dec(
    input logic [BW-1:0] b
  );
    logic [BW-1:0] t;
    logic          borrow;
    t = b;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (borrow) begin
        if (t[4*i +: 4] == 4'd0) begin
          t[4*i +: 4] = 4'd9;
        end else begin
          t[4*i +: 4] = t[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    return t;
  endfunction

  assign dur = (durSec == '0) ?
               DUR_W'(PERIOD_SEC) : durSec;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    seg_d   = seg_q;
    run_d   = run_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    if (abortSig) begin
      state_d = S_IDLE;
      rem_d   = '0;
      ps_d    = '0;
      seg_d   = '1;
      run_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (startSig) begin
            state_d = S_LOAD;
            rem_d   = dur;
            sh_d    = dur;
            bcd_d   = '0;
            cnt_d   = '0;
            seg_d   = '1;
            run_d   = 1'b1;
          end
        end
        S_LOAD: begin
          bcd_d = bcd_shift(bcd_q, sh_q[DUR_W-1]);
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_RUN;
            ps_d    = '0;
            seg_d   = seg_of(bcd_d);
          end
        end
`ifdef PERIOD_PAUSE_EN
        S_RUN: begin
          if (pauseSig) state_d = S_PAUSE;
          else          adv = 1'b1;
        end
        S_PAUSE: begin
          if (!pauseSig) begin
            state_d = S_RUN;
            adv     = 1'b1;
          end
        end
`else
        S_RUN: adv = 1'b1;
`endif
        S_DONE: begin
          state_d = S_IDLE;
          run_d   = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
      if (adv) begin
        if (ps_q == PS_MAX) begin
          ps_d = '0;
          if (rem_q == DUR_W'(1)) begin
            state_d = S_DONE;
            rem_d   = '0;
            bcd_d   = '0;
            seg_d   = seg_of('0);
            run_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            rem_d = rem_q - 1'b1;
            bcd_d = bcd_dec(bcd_q);
            seg_d = seg_of(bcd_d);
          end
        end else begin
          ps_d = ps_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      ps_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      seg_q   <= '1;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      seg_q   <= seg_d;
      run_q   <= run_d;
      done_q  <= done_d;
    end
  end

  assign running        = run_q;
  assign remaining      = rem_q;
  assign periodComplete = done_q;
  assign segOut         = seg_q;

endmodule

// File: tb/tb_period_timer.sv
// tb_period_timer: directed stimulus, every-cycle check against a
// time-count model of the countdown, plus literal spot checks.
module tb_period_timer;

  localparam int TICK = 4;
  localparam int DW   = 8;
  localparam int ND   = 4;
  localparam int PSEC = 5;
`ifdef PERIOD_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          pause = 1'b0;
  logic [DW-1:0] dur = '0;
  logic          running;
  logic [DW-1:0] remaining;
  logic          pulse;
  logic [8*ND-1:0] seg;

  int total = 0;
  int bad   = 0;
  int e     = 0;
  bit chk_en = 1'b0;

  period_timer #(
    .TICK_DIV   (TICK),
    .DUR_W      (DW),
    .PERIOD_SEC (PSEC),
    .NUM_DIGITS (ND)
  ) dut (
    .Clk100M        (clk),
    .RstN           (rst_n),
    .startSig       (start),
    .abortSig       (abort),
    .pauseSig       (pause),
    .durSec         (dur),
    .running        (running),
    .remaining      (remaining),
    .periodComplete (pulse),
    .segOut         (seg)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 load, 2 counting, 3 done
  int m_phase = 0;
  int m_dur   = 0;
  int m_k     = 0;
  int m_adv   = 0;
  bit m_zero  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_dur   = 0;
      m_k     = 0;
      m_adv   = 0;
      m_zero  = 1'b0;
    end else if (abort) begin
      m_phase = 0;
      m_zero  = 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_dur   = (dur == 0) ? PSEC : int'(dur);
          m_k     = 0;
          m_phase = 1;
          m_zero  = 1'b0;
        end
        1: begin
          m_k++;
          if (m_k == DW) begin
            m_phase = 2;
            m_adv   = 0;
          end
        end
        2: begin
          if (!(PEN && pause)) m_adv++;
          if (m_adv == m_dur * TICK) m_phase = 3;
        end
        3: begin
          m_phase = 0;
          m_zero  = 1'b1;
        end
        default: m_phase = 0;
      endcase
    end
  end

  function automatic logic [7:0] dig7(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [31:0] num_seg(input int v);
    logic [31:0] s;
    int x;
    x = v;
    for (int i = 0; i < ND; i++) begin
      s[8*i +: 8] = dig7(x % 10);
      x = x / 10;
    end
    return s;
  endfunction

  function automatic int exp_rem();
    if (m_phase == 1) return m_dur;
    if (m_phase == 2) return m_dur - m_adv / TICK;
    return 0;
  endfunction

  function automatic logic [31:0] exp_seg();
    if (m_phase == 2) return num_seg(exp_rem());
    if (m_phase == 3) return num_seg(0);
    if (m_phase == 0 && m_zero) return num_seg(0);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s e=%0d got=%h want=%h",
               nm, e, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_running", 32'(running),
          32'(m_phase == 1 || m_phase == 2));
      chk("m_remaining", 32'(remaining), 32'(exp_rem()));
      chk("m_pulse", 32'(pulse), 32'(m_phase == 3));
      chk("m_seg", seg, exp_seg());
    end
  end

  task automatic tick_to(input int t);
    while (e < t) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic go(input logic [DW-1:0] d);
    start = 1'b1;
    dur   = d;
    @(negedge clk);
    start = 1'b0;
    e     = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_rem", 32'(remaining), 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_seg", seg, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // duration 3
    go(8'd3);
    tick_to(1);
    chk("d3_running", 32'(running), 32'd1);
    tick_to(8);
    chk("d3_rem8", 32'(remaining), 32'd3);
    chk("d3_seg8", seg, 32'hC0C0_C0B0);
    tick_to(12);
    chk("d3_rem12", 32'(remaining), 32'd2);
    tick_to(16);
    chk("d3_rem16", 32'(remaining), 32'd1);
    tick_to(19);
    chk("d3_pulse19", 32'(pulse), 32'd0);
    tick_to(20);
    chk("d3_pulse20", 32'(pulse), 32'd1);
    chk("d3_seg20", seg, 32'hC0C0_C0C0);
    tick_to(21);
    chk("d3_pulse21", 32'(pulse), 32'd0);
    chk("d3_run21", 32'(running), 32'd0);
    tick_to(24);
    chk("d3_seg_hold", seg, 32'hC0C0_C0C0);

    // duration 0 selects default
    go(8'd0);
    tick_to(8);
    chk("d0_rem", 32'(remaining), 32'd5);
    chk("d0_seg", seg, 32'hC0C0_C092);
    tick_to(27);
    chk("d0_pulse27", 32'(pulse), 32'd0);
    tick_to(28);
    chk("d0_pulse28", 32'(pulse), 32'd1);
    tick_to(30);

    // duration 255, borrow across digits
    go(8'd255);
    tick_to(8);
    chk("d255_seg", seg, 32'hC0A4_9292);
    tick_to(12);
    chk("d254_seg", seg, 32'hC0A4_9299);
    chk("d254_rem", 32'(remaining), 32'd254);
    tick_to(628);
    chk("d100_seg", seg, 32'hC0F9_C0C0);
    tick_to(632);
    chk("d99_seg", seg, 32'hC0C0_9090);
    chk("d99_rem", 32'(remaining), 32'd99);
    abort = 1'b1;
    tick_to(633);
    abort = 1'b0;
    chk("d255_ab_seg", seg, 32'hFFFF_FFFF);
    chk("d255_ab_rem", 32'(remaining), 32'd0);

    // abort sampled at edge 16
    go(8'd3);
    tick_to(15);
    abort = 1'b1;
    tick_to(16);
    abort = 1'b0;
    chk("ab_running", 32'(running), 32'd0);
    chk("ab_rem", 32'(remaining), 32'd0);
    chk("ab_seg", seg, 32'hFFFF_FFFF);
    tick_to(30);
    chk("ab_pulse", 32'(pulse), 32'd0);

    // start+abort together, then start held across DONE
    start = 1'b1;
    abort = 1'b1;
    dur   = 8'd1;
    @(negedge clk);
    abort = 1'b0;
    chk("sa_idle", 32'(running), 32'd0);
    @(negedge clk);
    e = 0;
    chk("sa_run", 32'(running), 32'd1);
    tick_to(12);
    chk("held_pulse", 32'(pulse), 32'd1);
    tick_to(13);
    chk("held_idle", 32'(running), 32'd0);
    tick_to(14);
    chk("held_restart", 32'(running), 32'd1);
    start = 1'b0;
    abort = 1'b1;
    tick_to(15);
    abort = 1'b0;

    // pause sampled high at edges 10..19
    go(8'd2);
    tick_to(9);
    pause = 1'b1;
    tick_to(15);
`ifdef PERIOD_PAUSE_EN
    chk("pz_rem15", 32'(remaining), 32'd2);
`else
    chk("pz_rem15", 32'(remaining), 32'd1);
    chk("pz_pulse15", 32'(pulse), 32'd0);
    tick_to(16);
    chk("pz_pulse16", 32'(pulse), 32'd1);
`endif
    tick_to(19);
    pause = 1'b0;
`ifdef PERIOD_PAUSE_EN
    tick_to(25);
    chk("pz_pulse25", 32'(pulse), 32'd0);
    tick_to(26);
    chk("pz_pulse26", 32'(pulse), 32'd1);
`endif
    tick_to(30);

    // asynchronous reset mid-run
    go(8'd4);
    tick_to(10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_running", 32'(running), 32'd0);
    chk("ar_rem", 32'(remaining), 32'd0);
    chk("ar_pulse", 32'(pulse), 32'd0);
    chk("ar_seg", seg, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
